lif_tdm_scheduler: RTL and testbench

- Time-multiplexed controller sharing one leak/integrate/fire datapath across N_NEURONS virtual LIF neurons.
- Holds every neuron's membrane potential in an internal register file.
- Accepts weighted synaptic events between timesteps. On each timestep tick it sweeps all neurons in index order: fire/reset or leak.
- Emits spike events via a valid/ready handshake toward the routing fabric.

---
 rtl/lif_tdm_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_lif_tdm_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler
// -----------------
// Time-multiplexed leak/integrate/fire controller. One datapath serves
// N_NEURONS virtual neurons whose membrane potentials live in an internal
// register file. Between timesteps it accepts weighted synaptic events.
// On each tick it sweeps the neurons in index order, one per cycle.
// A neuron at or above threshold is cleared and reported as a spike.
// Otherwise it leaks by V >> leak_shift.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   tick_i         timestep strobe (one-cycle pulse)
//   syn_valid_i    synaptic event present
//   syn_idx_i      target neuron of the event
//   syn_weight_i   unsigned saturating increment
//   syn_ready_o    event accepted when syn_valid_i && syn_ready_o
//   threshold_i    firing threshold, static during a sweep
//   leak_shift_i   leak = V >> leak_shift_i, 0 disables leak
//   spike_valid_o  spike event present
//   spike_idx_o    index of the firing neuron
//   spike_ready_i  downstream accepts the spike
//   busy_o         high whenever the controller is not idle
//   step_done_o    one-cycle pulse at the end of a sweep
//   overrun_o      sticky: a tick was dropped
//   rd_idx_i       debug readback index
//   rd_v_o         V[rd_idx_i], registered, one-cycle latency
module lif_tdm_scheduler #(
  parameter int N_NEURONS = 8,
  parameter int IDX_W     = 3,
  parameter int V_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             syn_valid_i,
  input  logic [IDX_W-1:0] syn_idx_i,
  input  logic [V_W-1:0]   syn_weight_i,
  output logic             syn_ready_o,
  input  logic [V_W-1:0]   threshold_i,
  input  logic [2:0]       leak_shift_i,
  output logic             spike_valid_o,
  output logic [IDX_W-1:0] spike_idx_o,
  input  logic             spike_ready_i,
  output logic             busy_o,
  output logic             step_done_o,
  output logic             overrun_o,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [V_W-1:0]   rd_v_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_SPIKE,
    ST_DONE
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [V_W-1:0]   v_q [N_NEURONS];
  logic             pending_q;
  logic             overrun_q;
  logic             syn_ready_q;
  logic             spike_valid_q;
  logic [IDX_W-1:0] spike_idx_q;
  logic             busy_q;
  logic             step_done_q;
  logic [V_W-1:0]   rd_v_q;

  // Shared datapath: saturating integrate for the event port, and
  // fire/leak evaluation for the neuron under the sweep pointer.
  logic [V_W:0]   sum_wide;
  logic [V_W-1:0] syn_sum_d;
  logic [V_W-1:0] v_cur;
  logic [V_W-1:0] leak_amt;
  logic [V_W-1:0] v_sweep_d;
  logic           fire;
  logic           syn_we;
  logic           sweep_we;

  always_comb begin
    v_cur     = v_q[ptr_q];
    sum_wide  = {1'b0, v_q[syn_idx_i]} + {1'b0, syn_weight_i};
    // Carry out means the sum exceeded full scale: clamp instead of wrap.
    syn_sum_d = sum_wide[V_W] ? {V_W{1'b1}} : sum_wide[V_W-1:0];
    // A shift of zero would subtract V from itself, so it means "no leak".
    leak_amt  = (leak_shift_i == 3'd0) ? '0 : (v_cur >> leak_shift_i);
    // Fire is judged on the un-leaked potential.
    fire      = (v_cur >= threshold_i);
    v_sweep_d = fire ? '0 : (v_cur - leak_amt);
    syn_we    = (state_q == ST_IDLE) && syn_valid_i && syn_ready_q;
    sweep_we  = (state_q == ST_SWEEP);
  end

  // Membrane potential register file. Event writes happen only in IDLE and
  // sweep writes only in SWEEP, so the two ports never collide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= '0;
      end
    end else begin
      if (syn_we) begin
        v_q[syn_idx_i] <= syn_sum_d;
      end
      if (sweep_we) begin
        v_q[ptr_q] <= v_sweep_d;
      end
    end
  end

  // Debug readback samples the array as it stands, including mid-sweep.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_v_q <= '0;
    end else begin
      rd_v_q <= v_q[rd_idx_i];
    end
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      syn_ready_q   <= 1'b0;
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
      busy_q        <= 1'b0;
      step_done_q   <= 1'b0;
    end else begin
      // A tick while busy is remembered once; a second one is lost.
      if ((state_q != ST_IDLE) && tick_i) begin
        if (pending_q) begin
          overrun_q <= 1'b1;
        end else begin
          pending_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (tick_i || pending_q) begin
            state_q     <= ST_SWEEP;
            ptr_q       <= '0;
            pending_q   <= 1'b0;
            syn_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end else begin
            syn_ready_q <= 1'b1;
          end
        end

        ST_SWEEP: begin
          if (fire) begin
            spike_valid_q <= 1'b1;
            spike_idx_q   <= ptr_q;
            state_q       <= ST_SPIKE;
          end else if (ptr_q == LAST_IDX) begin
            step_done_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end

        ST_SPIKE: begin
          // Pointer stays frozen until the spike is taken downstream.
          if (spike_ready_i) begin
            spike_valid_q <= 1'b0;
            if (ptr_q == LAST_IDX) begin
              step_done_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              ptr_q   <= ptr_q + 1'b1;
              state_q <= ST_SWEEP;
            end
          end
        end

        ST_DONE: begin
          step_done_q <= 1'b0;
          busy_q      <= 1'b0;
          syn_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign syn_ready_o   = syn_ready_q;
  assign spike_valid_o = spike_valid_q;
  assign spike_idx_o   = spike_idx_q;
  assign busy_o        = busy_q;
  assign step_done_o   = step_done_q;
  assign overrun_o     = overrun_q;
  assign rd_v_o        = rd_v_q;

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Testbench for lif_tdm_scheduler: directed scenarios plus randomized
// timesteps, with a queue-based scoreboard fed by a behavioural model.
module tb_lif_tdm_scheduler;

  localparam int N     = 8;
  localparam int IDX_W = 3;
  localparam int V_W   = 8;
  localparam int VMAX  = (1 << V_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tick;
  logic             syn_valid;
  logic [IDX_W-1:0] syn_idx;
  logic [V_W-1:0]   syn_weight;
  logic             syn_ready;
  logic [V_W-1:0]   threshold;
  logic [2:0]       leak_shift;
  logic             spike_valid;
  logic [IDX_W-1:0] spike_idx;
  logic             spike_ready;
  logic             busy;
  logic             step_done;
  logic             overrun;
  logic [IDX_W-1:0] rd_idx;
  logic [V_W-1:0]   rd_v;

  always #5 clk = ~clk;

  lif_tdm_scheduler #(.N_NEURONS(N), .IDX_W(IDX_W), .V_W(V_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick),
    .syn_valid_i(syn_valid), .syn_idx_i(syn_idx), .syn_weight_i(syn_weight),
    .syn_ready_o(syn_ready), .threshold_i(threshold), .leak_shift_i(leak_shift),
    .spike_valid_o(spike_valid), .spike_idx_o(spike_idx), .spike_ready_i(spike_ready),
    .busy_o(busy), .step_done_o(step_done), .overrun_o(overrun),
    .rd_idx_i(rd_idx), .rd_v_o(rd_v)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Behavioural model: potentials as plain integers, sweeps as whole steps.
  int model_v [N];
  int exp_spk_q [$];   // expected spike indices in emission order
  int exp_done_q [$];  // expected spike count of each sweep

  task automatic model_sweep();
    int n;
    int thr;
    int sh;
    n   = 0;
    thr = int'(threshold);
    sh  = int'(leak_shift);
    for (int i = 0; i < N; i++) begin
      if (model_v[i] >= thr) begin
        exp_spk_q.push_back(i);
        model_v[i] = 0;
        n++;
      end else if (sh != 0) begin
        model_v[i] = model_v[i] - (model_v[i] / (1 << sh));
      end
    end
    exp_done_q.push_back(n);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) model_v[i] = 0;
    exp_spk_q.delete();
    exp_done_q.delete();
  endtask

  // Random backpressure driver.
  bit rand_ready = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) spike_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops expected spikes on each handshake and checks every sweep's
  // spike count and length (N + spikes + stall cycles + the DONE cycle).
  int   spk_seen = 0;
  int   busy_cnt = 0;
  int   stall_cnt = 0;
  bit   prev_hold = 1'b0;
  int   prev_idx = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        spk_seen = 0; busy_cnt = 0; stall_cnt = 0; prev_hold = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        if (spike_valid) begin
          if (prev_hold) chk("spike_idx_hold", int'(spike_idx), prev_idx);
          if (spike_ready) begin
            if (exp_spk_q.size() == 0) chk("spike_unexpected", int'(spike_idx), -1);
            else chk("spike_idx", int'(spike_idx), exp_spk_q.pop_front());
            spk_seen++;
          end else begin
            stall_cnt++;
          end
          prev_hold = !spike_ready;
          prev_idx  = int'(spike_idx);
        end else begin
          prev_hold = 1'b0;
        end
        if (step_done) begin
          if (exp_done_q.size() == 0) begin
            chk("step_done_unexpected", 1, 0);
          end else begin
            int e;
            e = exp_done_q.pop_front();
            chk("sweep_spikes", spk_seen, e);
            chk("sweep_cycles", busy_cnt, N + e + stall_cnt + 1);
          end
          spk_seen = 0; busy_cnt = 0; stall_cnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 3 && n < 3000) begin
      step();
      n++;
      if (!busy && !spike_valid) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic wait_spike_valid();
    int n;
    n = 0;
    while (!spike_valid && n < 100) begin
      step();
      n++;
    end
    if (!spike_valid) chk("wait_spike_timeout", 0, 1);
  endtask

  task automatic set_cfg(input int thr, input int sh);
    threshold  = V_W'(thr);
    leak_shift = 3'(sh);
  endtask

  task automatic send_event(input int idx, input int w, input bit with_tick);
    syn_valid  = 1'b1;
    syn_idx    = IDX_W'(idx);
    syn_weight = V_W'(w);
    tick       = with_tick;
    chk("syn_ready_idle", int'(syn_ready), 1);
    step();
    syn_valid = 1'b0;
    tick      = 1'b0;
    model_v[idx] = (model_v[idx] + w > VMAX) ? VMAX : model_v[idx] + w;
    if (with_tick) model_sweep();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    model_sweep();
  endtask

  task automatic check_rd(input int idx);
    rd_idx = IDX_W'(idx);
    step();
    chk($sformatf("rd_v[%0d]", idx), int'(rd_v), model_v[idx]);
  endtask

  task automatic clear_all();
    set_cfg(0, 0);
    spike_ready = 1'b1;
    do_tick();
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tick = 1'b0; syn_valid = 1'b0; syn_idx = '0; syn_weight = '0;
    threshold = 8'd255; leak_shift = 3'd0; spike_ready = 1'b0; rd_idx = '0;
    model_clear();

    // Reset and readback
    repeat (3) step();
    chk("rst_syn_ready", int'(syn_ready), 0);
    chk("rst_spike_valid", int'(spike_valid), 0);
    chk("rst_spike_idx", int'(spike_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_step_done", int'(step_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_rd_v", int'(rd_v), 0);
    rst_n = 1'b1;
    step();
    chk("syn_ready_after_release", int'(syn_ready), 1);
    for (int i = 0; i < N; i++) check_rd(i);

    // Saturating integrate, then fire at full scale
    set_cfg(255, 0);
    spike_ready = 1'b1;
    send_event(2, 200, 1'b0);
    send_event(2, 100, 1'b0);
    check_rd(2);
    chk("sat_v2_full_scale", int'(rd_v), VMAX);
    do_tick();
    wait_idle();
    check_rd(2);

    // Leak versus fire
    clear_all();
    set_cfg(100, 2);
    send_event(0, 80, 1'b0);
    send_event(5, 120, 1'b0);
    do_tick();
    wait_idle();
    check_rd(0);
    check_rd(5);

    // Backpressure: first spike held for five cycles
    clear_all();
    set_cfg(10, 1);
    send_event(1, 50, 1'b0);
    send_event(3, 50, 1'b0);
    spike_ready = 1'b0;
    do_tick();
    wait_spike_valid();
    repeat (5) begin
      step();
      chk("bp_valid_held", int'(spike_valid), 1);
      chk("bp_idx_held", int'(spike_idx), 1);
    end
    spike_ready = 1'b1;
    wait_idle();
    chk("bp_spikes_left", exp_spk_q.size(), 0);

    // Tick during a sweep: one pending sweep, no overrun
    set_cfg(60, 1);
    send_event(4, 90, 1'b0);
    send_event(6, 30, 1'b0);
    do_tick();
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    model_sweep();
    begin
      int n;
      n = 0;
      while (!step_done && n < 100) begin
        step();
        n++;
      end
      chk("collide_done_seen", int'(step_done), 1);
    end
    step();
    chk("collide_idle_gap", int'(busy), 0);
    step();
    chk("collide_second_sweep", int'(busy), 1);
    wait_idle();
    chk("collide_overrun", int'(overrun), 0);

    // Two ticks during one sweep: overrun and a single extra sweep
    send_event(7, 250, 1'b0);
    do_tick();
    step();
    tick = 1'b1; step(); tick = 1'b0; step();
    tick = 1'b1; step(); tick = 1'b0;
    model_sweep();
    wait_idle();
    chk("overrun_set", int'(overrun), 1);
    chk("overrun_done_left", exp_done_q.size(), 0);
    for (int i = 0; i < N; i++) check_rd(i);

    // Randomized timesteps with random backpressure
    rand_ready = 1'b1;
    for (int it = 0; it < 25; it++) begin
      int ne;
      set_cfg(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, VMAX),
              $urandom_range(0, 7));
      ne = $urandom_range(0, 4);
      for (int e = 0; e < ne; e++)
        send_event($urandom_range(0, N - 1), $urandom_range(0, VMAX), 1'b0);
      if ($urandom_range(0, 1) == 1)
        send_event($urandom_range(0, N - 1), $urandom_range(0, VMAX), 1'b1);
      else
        do_tick();
      wait_idle();
      check_rd($urandom_range(0, N - 1));
      check_rd($urandom_range(0, N - 1));
    end
    rand_ready = 1'b0;
    spike_ready = 1'b1;
    step();
    chk("rand_spikes_left", exp_spk_q.size(), 0);

    // Reset while a spike is waiting
    set_cfg(0, 0);
    spike_ready = 1'b0;
    do_tick();
    wait_spike_valid();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_spike_valid", int'(spike_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_syn_ready", int'(syn_ready), 0);
    model_clear();
    step();
    step();
    rst_n = 1'b1;
    spike_ready = 1'b1;
    step();
    chk("midrst_syn_ready_after", int'(syn_ready), 1);
    chk("midrst_overrun", int'(overrun), 0);
    for (int i = 0; i < N; i++) check_rd(i);

    // Sweep after reset, with event and tick in the same cycle
    set_cfg(50, 1);
    send_event(3, 70, 1'b0);
    send_event(6, 40, 1'b1);
    wait_idle();
    check_rd(3);
    check_rd(6);
    chk("end_spikes_left", exp_spk_q.size(), 0);
    chk("end_sweeps_left", exp_done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
